voice_scheduler: RTL
====================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NVOICE, default 4, number of time-multiplexed voices sharing one wave table.
REQ-002 Parameter PHASE_W, default 16, phase accumulator width per voice.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sample_tick  input  1  one-cycle pulse starting one output-sample computation.
REQ-006 note_on  input  1  one-cycle pulse requesting a voice for key note_id.
REQ-007 note_off  input  1  one-cycle pulse releasing the voice holding note_id.
REQ-008 note_id  input  4  key identifier for note_on/note_off.
REQ-009 note_inc  input  PHASE_W  phase increment per sample for note_on.
REQ-010 table_select  output  6  address to shared wave table.
REQ-011 table_wave  input  16  combinational table data, signed two's complement.
REQ-012 sample_out  output  16  signed mixed sample, registered.
REQ-013 sample_valid  output  1  one-cycle pulse, sample_out updated.
REQ-014 tick_overrun  output  1  one-cycle pulse, sample_tick arrived while busy.
REQ-015 voice_busy  output  NVOICE  per-voice active flags.

Function
REQ-016 Per voice: active bit, note_id, inc, phase; table_select for voice v = phase[v][PHASE_W-1:PHASE_W-6].
REQ-017 note_on: allocate lowest-index inactive voice, load id/inc, phase=0, active=1, effective next cycle.
REQ-018 note_on with all voices active: steal voice at round-robin pointer steal_ptr, then steal_ptr = steal_ptr+1 mod NVOICE.
REQ-019 note_on with id already active: retrigger that voice (phase=0, new inc), no new allocation.
REQ-020 note_off: clear active of every voice matching note_id; no match, no effect.
REQ-021 note_on and note_off same cycle, same id: note_off wins; different ids: both apply.
REQ-022 FSM states IDLE, SEL, ACC, OUT; IDLE->SEL on sample_tick with acc=0, v=0.
REQ-023 SEL: drive table_select for voice v, one cycle; SEL->ACC.
REQ-024 ACC: acc += sign-extended table_wave if voice v active, else +0; phase[v] += inc[v] mod 2^PHASE_W if active; v==NVOICE-1 ->OUT else v+1, ->SEL.
REQ-025 acc width 16+clog2(NVOICE) bits, never overflows.
REQ-026 OUT: sample_out = acc arithmetic-shifted right by clog2(NVOICE); sample_valid=1 one cycle; ->IDLE.
REQ-027 Latency sample_tick to sample_valid = 2*NVOICE+2 cycles (10 at default).
REQ-028 sample_tick outside IDLE: ignored, tick_overrun pulses same cycle+1.
REQ-029 note_on/off during SEL/ACC apply immediately; a voice allocated mid-sweep contributes from the next sample at phase 0 (its phase is not advanced in the current sweep if already passed, or contributes phase 0 if not yet reached).
REQ-030 table_select in IDLE/OUT = 0.

Reset
REQ-031 rst_n low: state IDLE, all active=0, phases/inc/ids=0, steal_ptr=0, acc=0, sample_out=0, sample_valid=0, tick_overrun=0, table_select=0.
REQ-032 Reset mid-sweep aborts computation; no sample_valid issued for that tick.

Structure
REQ-033 Shared package holds NVOICE, PHASE_W, table address width 6, FSM state encodings.
REQ-034 One sub-module voice_alloc: combinational free-voice priority encoder plus id-match vector.

Verification
REQ-035 Reset, one tick, no notes -> sample_valid 10 cycles later, sample_out=0.
REQ-036 note_on id=1 inc=0x0400; ticks -> table_select per sweep 0,1,2,...; sample_out = table_wave>>>2.
REQ-037 Five note_on distinct ids, 4 voices -> fifth steals voice 0; next steal voice 1.
REQ-038 note_on id=3 then note_off id=3 -> voice_busy=0, following sample_out=0.
REQ-039 sample_tick at cycle 3 of sweep -> tick_overrun pulse, single sample_valid.
REQ-040 rst_n low during ACC -> all outputs reset, no sample_valid; next tick normal.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler.
// Holds the default voice count, phase width, wave-table address/data widths,
// the key-id width and the sweep FSM state encoding.
package voice_scheduler_pkg;
    localparam int NVOICE_DEF  = 4;
    localparam int PHASE_W_DEF = 16;
    localparam int TSEL_W      = 6;
    localparam int WAVE_W      = 16;
    localparam int ID_W        = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;
endpackage

// File: rtl/voice_scheduler_alloc.sv
// voice_alloc: combinational voice lookup.
// Ports:
//   active     in  per-voice active flags
//   ids        in  per-voice key ids
//   note_id    in  key being requested / released
//   free_found out some voice is inactive
//   free_idx   out lowest-index inactive voice
//   match      out active voices whose id equals note_id
module voice_alloc
    import voice_scheduler_pkg::*;
#(
    parameter int NVOICE = NVOICE_DEF,
    parameter int VW     = 2
) (
    input  logic [NVOICE-1:0]           active,
    input  logic [NVOICE-1:0][ID_W-1:0] ids,
    input  logic [ID_W-1:0]             note_id,
    output logic                        free_found,
    output logic [VW-1:0]               free_idx,
    output logic [NVOICE-1:0]           match
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        match      = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_found = 1'b1;
                free_idx   = VW'(i);
            end
            match[i] = active[i] && (ids[i] == note_id);
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes NVOICE phase-accumulator voices onto one
// shared wave table and mixes them into a single sample per sample_tick.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sample_tick    start one mix sweep (ignored and flagged when busy)
//   note_on/off    allocate / release a voice for note_id (note_inc on note_on)
//   table_select   wave-table address for the voice being visited
//   table_wave     signed table data, combinational from table_select
//   sample_out     registered mixed sample, sample_valid pulses on update
//   tick_overrun   pulses the cycle after a tick arrives outside IDLE
//   voice_busy     per-voice active flags
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NVOICE  = NVOICE_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               note_on,
    input  logic               note_off,
    input  logic [3:0]         note_id,
    input  logic [PHASE_W-1:0] note_inc,
    output logic [5:0]         table_select,
    input  logic [15:0]        table_wave,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               tick_overrun,
    output logic [NVOICE-1:0]  voice_busy
);

    localparam int SH    = $clog2(NVOICE);
    localparam int VW    = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam int ACC_W = WAVE_W + SH;
    localparam logic [VW-1:0] LAST = VW'(NVOICE - 1);

    state_t                       state, state_n;
    logic [VW-1:0]                v;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      wave_ext;
    logic signed [ACC_W-1:0]      sh_acc;

    logic [NVOICE-1:0]            active;
    logic [NVOICE-1:0][ID_W-1:0]  ids;
    logic [NVOICE-1:0][PHASE_W-1:0] inc;
    logic [NVOICE-1:0][PHASE_W-1:0] phase;
    logic [VW-1:0]                steal_ptr;

    logic                         free_found;
    logic [VW-1:0]                free_idx;
    logic [NVOICE-1:0]            match;
    logic [NVOICE-1:0]            load;
    logic [NVOICE-1:0]            off_clr;
    logic                         steal;
    logic [PHASE_W-1:0]           cur_phase;

    voice_alloc #(
        .NVOICE (NVOICE),
        .VW     (VW)
    ) u_alloc (
        .active     (active),
        .ids        (ids),
        .note_id    (note_id),
        .free_found (free_found),
        .free_idx   (free_idx),
        .match      (match)
    );

    // note_on and note_off share note_id, so a same-cycle pair always names
    // the same key and the release takes precedence.
    always_comb begin
        load    = '0;
        off_clr = '0;
        steal   = 1'b0;
        if (note_off)
            off_clr = match;
        if (note_on && !note_off) begin
            if (|match)
                load = match;              // retrigger, no new allocation
            else if (free_found)
                load[free_idx] = 1'b1;
            else begin
                load[steal_ptr] = 1'b1;
                steal           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (sample_tick) state_n = S_SEL;
            S_SEL:   state_n = S_ACC;
            S_ACC:   state_n = (v == LAST) ? S_OUT : S_SEL;
            S_OUT:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Address stays on the visited voice through ACC so table_wave is stable
    // when it is accumulated.
    assign cur_phase    = phase[v];
    assign table_select = (state == S_SEL || state == S_ACC) ?
                          cur_phase[PHASE_W-1 -: TSEL_W] : '0;
    assign wave_ext     = ACC_W'(signed'(table_wave));
    assign sh_acc       = acc >>> SH;
    assign voice_busy   = active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v            <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            tick_overrun <= 1'b0;
            steal_ptr    <= '0;
        end else begin
            sample_valid <= 1'b0;
            tick_overrun <= sample_tick && (state != S_IDLE);
            case (state)
                S_IDLE: if (sample_tick) begin
                    acc <= '0;
                    v   <= '0;
                end
                S_ACC: begin
                    if (active[v])
                        acc <= acc + wave_ext;
                    if (v != LAST)
                        v <= v + 1'b1;
                end
                S_OUT: begin
                    sample_out   <= sh_acc[WAVE_W-1:0];
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
            if (steal)
                steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
        end
    end

    // Per-voice state. A load overrides both release and phase advance so a
    // voice (re)allocated mid-sweep always starts from phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            ids    <= '0;
            inc    <= '0;
            phase  <= '0;
        end else begin
            for (int i = 0; i < NVOICE; i++) begin
                if (state == S_ACC && v == VW'(i) && active[i])
                    phase[i] <= phase[i] + inc[i];
                if (off_clr[i])
                    active[i] <= 1'b0;
                if (load[i]) begin
                    active[i] <= 1'b1;
                    ids[i]    <= note_id;
                    inc[i]    <= note_inc;
                    phase[i]  <= '0;
                end
            end
        end
    end

endmodule
